// File: rtl/axi_ctrl_pkg.sv
// Shared types and helpers for the AXI drain controller: FSM state encoding and
// counter sizing.
package axi_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_ISOLATED = 2'd2
   } drain_state_t;

   localparam int DEF_MAX_OUTSTANDING = 8;

   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Up/down transaction counter. A decrement at zero is ignored and reported on
// underflow_o; simultaneous inc/dec leaves the count unchanged.
module axi_txn_counter #(
   parameter int CNT_W = 4
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             underflow_o
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_do_inc;
   logic             w_do_dec;

   assign underflow_o = dec_i & (r_cnt == '0);
   assign w_do_inc    = inc_i & ~(&r_cnt);
   assign w_do_dec    = dec_i & ~underflow_o;
   assign cnt_o       = r_cnt;

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else begin
         case ({w_do_inc, w_do_dec})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/axi_drain_ctrl.sv
// Valid/ready gate for one AXI port: caps outstanding reads/writes and, on
// request, drains the port and acknowledges once it is empty and isolated.
module axi_drain_ctrl
   import axi_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             s_aw_valid_i,
   output logic             s_aw_ready_o,
   output logic             m_aw_valid_o,
   input  logic             m_aw_ready_i,
   input  logic             s_ar_valid_i,
   output logic             s_ar_ready_o,
   output logic             m_ar_valid_o,
   input  logic             m_ar_ready_i,
   input  logic             s_w_valid_i,
   output logic             s_w_ready_o,
   output logic             m_w_valid_o,
   input  logic             m_w_ready_i,
   input  logic             w_last_i,
   input  logic             b_valid_i,
   input  logic             b_ready_i,
   input  logic             r_valid_i,
   input  logic             r_ready_i,
   input  logic             r_last_i,
   input  logic             drain_req_i,
   output logic             drain_ack_o,
   output logic [CNT_W-1:0] wr_cnt_o,
   output logic [CNT_W-1:0] rd_cnt_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   drain_state_t     r_state;
   drain_state_t     w_state_nxt;
   logic [CNT_W-1:0] w_owed_cnt;
   logic             r_aw_hold, r_ar_hold, r_w_hold, r_err;
   logic             w_aw_en, w_ar_en, w_w_en;
   logic             w_aw_pass, w_ar_pass, w_w_pass;
   logic             w_hs_aw, w_hs_ar, w_hs_w, w_hs_wl, w_hs_b, w_hs_rl;
   logic             w_wr_unf, w_rd_unf, w_owed_unused_unf;
   logic             w_empty;

   assign w_aw_pass    = w_aw_en | r_aw_hold;
   assign w_ar_pass    = w_ar_en | r_ar_hold;
   assign w_w_pass     = w_w_en;
   assign m_aw_valid_o = s_aw_valid_i & w_aw_pass;
   assign s_aw_ready_o = m_aw_ready_i & w_aw_pass;
   assign m_ar_valid_o = s_ar_valid_i & w_ar_pass;
   assign s_ar_ready_o = m_ar_ready_i & w_ar_pass;
   assign m_w_valid_o  = s_w_valid_i & w_w_pass;
   assign s_w_ready_o  = m_w_ready_i & w_w_pass;

   assign w_hs_aw = m_aw_valid_o & m_aw_ready_i;
   assign w_hs_ar = m_ar_valid_o & m_ar_ready_i;
   assign w_hs_w  = m_w_valid_o & m_w_ready_i;
   assign w_hs_wl = w_hs_w & w_last_i;
   assign w_hs_b  = b_valid_i & b_ready_i;
   assign w_hs_rl = r_valid_i & r_ready_i & r_last_i;
   assign err_o   = r_err;

   assign w_empty = (wr_cnt_o == '0) && (rd_cnt_o == '0) && (w_owed_cnt == '0)
                    && !r_aw_hold && !r_ar_hold;

   axi_txn_counter #(.CNT_W(CNT_W)) u_wr_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_hs_aw), .dec_i(w_hs_b),
      .cnt_o(wr_cnt_o), .underflow_o(w_wr_unf)
   );

   axi_txn_counter #(.CNT_W(CNT_W)) u_rd_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_hs_ar), .dec_i(w_hs_rl),
      .cnt_o(rd_cnt_o), .underflow_o(w_rd_unf)
   );

   // W data may legally lead its AW, so a W-last with nothing owed is not an error.
   axi_txn_counter #(.CNT_W(CNT_W)) u_w_owed (
      .clk_i(clk_i), .rst_i(rst_i), .inc_i(w_hs_aw), .dec_i(w_hs_wl),
      .cnt_o(w_owed_cnt), .underflow_o(w_owed_unused_unf)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:      if (drain_req_i) w_state_nxt = ST_DRAIN;
         ST_DRAIN:    if (!drain_req_i) w_state_nxt = ST_RUN;
                      else if (w_empty) w_state_nxt = ST_ISOLATED;
         ST_ISOLATED: if (!drain_req_i) w_state_nxt = ST_RUN;
         default:     w_state_nxt = ST_RUN;
      endcase
   end

   // Enables use the registered counts, so a slot freed this cycle opens next cycle.
   always_comb begin
      w_aw_en     = (r_state == ST_RUN) && (wr_cnt_o < MAX_CNT);
      w_ar_en     = (r_state == ST_RUN) && (rd_cnt_o < MAX_CNT);
      w_w_en      = (r_state == ST_RUN) || (w_owed_cnt != '0) || r_w_hold;
      drain_ack_o = (r_state == ST_ISOLATED);
   end

   // Hold flags keep an already-presented valid alive until its handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_aw_hold <= 1'b0;
         r_ar_hold <= 1'b0;
         r_w_hold  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_aw_hold <= (r_aw_hold | (m_aw_valid_o & ~m_aw_ready_i)) & ~w_hs_aw;
         r_ar_hold <= (r_ar_hold | (m_ar_valid_o & ~m_ar_ready_i)) & ~w_hs_ar;
         r_w_hold  <= (r_w_hold  | (m_w_valid_o  & ~m_w_ready_i))  & ~w_hs_w;
         r_err     <= r_err | w_wr_unf | w_rd_unf;
      end
   end

endmodule

// File: tb/tb_axi_drain_ctrl.sv
// Directed self-checking bench for axi_drain_ctrl with MAX_OUTSTANDING = 2.
module tb_axi_drain_ctrl;

   localparam int MAX = 2;
   localparam int CW  = $clog2(MAX + 1);

   logic          clk_i, rst_i;
   logic          s_aw_valid_i, s_aw_ready_o, m_aw_valid_o, m_aw_ready_i;
   logic          s_ar_valid_i, s_ar_ready_o, m_ar_valid_o, m_ar_ready_i;
   logic          s_w_valid_i, s_w_ready_o, m_w_valid_o, m_w_ready_i, w_last_i;
   logic          b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
   logic          drain_req_i, drain_ack_o, err_o;
   logic [CW-1:0] wr_cnt_o, rd_cnt_o;

   int n_cmp = 0;
   int n_err = 0;

   axi_drain_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o),
      .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i),
      .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
      .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
      .s_w_valid_i(s_w_valid_i), .s_w_ready_o(s_w_ready_o),
      .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .w_last_i(w_last_i),
      .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
      .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
      .drain_req_i(drain_req_i), .drain_ack_o(drain_ack_o),
      .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o), .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_r(input logic v);
      r_valid_i = v;
      r_ready_i = v;
      r_last_i  = v;
   endtask

   initial begin
      rst_i = 1'b1;
      s_aw_valid_i = 0; m_aw_ready_i = 0; s_ar_valid_i = 0; m_ar_ready_i = 0;
      s_w_valid_i = 0; m_w_ready_i = 0; w_last_i = 0;
      b_valid_i = 0; b_ready_i = 0; r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
      drain_req_i = 0;
      #2;
      check("rst_wr_cnt", wr_cnt_o, 0);
      check("rst_rd_cnt", rd_cnt_o, 0);
      check("rst_ack", drain_ack_o, 0);
      check("rst_err", err_o, 0);
      m_aw_ready_i = 1; #1;
      check("rst_aw_ready_open", s_aw_ready_o, 1);
      m_aw_ready_i = 0;
      tick(); tick();
      rst_i = 1'b0;

      // Read cap at MAX, reopened by one R-last
      s_ar_valid_i = 1; m_ar_ready_i = 1; #1;
      check("ar1_valid", m_ar_valid_o, 1);
      tick();
      check("ar2_valid", m_ar_valid_o, 1);
      check("ar_cnt1", rd_cnt_o, 1);
      tick();
      check("ar3_blocked", m_ar_valid_o, 0);
      check("ar3_ready_low", s_ar_ready_o, 0);
      check("ar_cnt2", rd_cnt_o, 2);
      tick();
      set_r(1); #1;
      check("ar3_blocked_during_r", m_ar_valid_o, 0);
      tick();
      set_r(0); #1;
      check("ar3_after_r", m_ar_valid_o, 1);
      check("ar_cnt_after_r", rd_cnt_o, 1);
      tick();
      s_ar_valid_i = 0; #1;
      check("ar_cnt_full_again", rd_cnt_o, 2);
      set_r(1); tick(); tick();
      set_r(0); m_ar_ready_i = 0; #1;
      check("ar_cnt_emptied", rd_cnt_o, 0);
      check("err_clean", err_o, 0);

      // Drain with one write in flight: W still passes, ack after B
      s_aw_valid_i = 1; m_aw_ready_i = 1; #1;
      check("aw_pass", m_aw_valid_o, 1);
      tick();
      s_aw_valid_i = 0; drain_req_i = 1; #1;
      check("wr_cnt_one", wr_cnt_o, 1);
      tick();
      s_aw_valid_i = 1; #1;
      check("drain_aw_blocked", m_aw_valid_o, 0);
      check("drain_aw_ready_low", s_aw_ready_o, 0);
      s_aw_valid_i = 0; m_aw_ready_i = 0;
      s_w_valid_i = 1; m_w_ready_i = 1; w_last_i = 0; #1;
      check("drain_w_beat_ready", s_w_ready_o, 1);
      check("drain_w_beat_valid", m_w_valid_o, 1);
      tick();
      w_last_i = 1; #1;
      check("drain_w_last_valid", m_w_valid_o, 1);
      tick();
      w_last_i = 0; #1;
      check("drain_w_after_last", s_w_ready_o, 0);
      s_w_valid_i = 0; m_w_ready_i = 0; #1;
      check("drain_no_ack_wr_pending", drain_ack_o, 0);
      b_valid_i = 1; b_ready_i = 1;
      tick();
      b_valid_i = 0; b_ready_i = 0; #1;
      check("drain_wr_cnt_zero", wr_cnt_o, 0);
      check("ack_not_yet", drain_ack_o, 0);
      tick();
      check("ack_asserted", drain_ack_o, 1);

      // Isolated: W blocked with nothing owed; release resumes traffic
      s_w_valid_i = 1; m_w_ready_i = 1; #1;
      check("iso_w_ready", s_w_ready_o, 0);
      check("iso_w_valid", m_w_valid_o, 0);
      s_ar_valid_i = 1; m_ar_ready_i = 1; #1;
      check("iso_ar_blocked", m_ar_valid_o, 0);
      s_ar_valid_i = 0; s_w_valid_i = 0; drain_req_i = 0;
      tick();
      check("release_ack_low", drain_ack_o, 0);
      s_w_valid_i = 1; s_ar_valid_i = 1; #1;
      check("resume_w_ready", s_w_ready_o, 1);
      check("resume_ar_valid", m_ar_valid_o, 1);
      tick();
      s_ar_valid_i = 0; s_w_valid_i = 0; m_w_ready_i = 0; m_ar_ready_i = 0;
      set_r(1); tick();
      set_r(0); #1;
      check("resume_rd_zero", rd_cnt_o, 0);

      // Held AR completes during drain; ack only after its R-last
      s_ar_valid_i = 1; m_ar_ready_i = 0; #1;
      check("hold_ar_valid", m_ar_valid_o, 1);
      check("hold_ar_ready_low", s_ar_ready_o, 0);
      tick();
      drain_req_i = 1;
      tick();
      check("hold_ar_kept_in_drain", m_ar_valid_o, 1);
      check("hold_rd_zero", rd_cnt_o, 0);
      tick();
      check("hold_no_ack", drain_ack_o, 0);
      m_ar_ready_i = 1; #1;
      check("hold_ar_ready", s_ar_ready_o, 1);
      tick();
      s_ar_valid_i = 0; m_ar_ready_i = 0; #1;
      check("hold_rd_one", rd_cnt_o, 1);
      s_ar_valid_i = 1; #1;
      check("hold_new_ar_blocked", m_ar_valid_o, 0);
      s_ar_valid_i = 0;
      tick();
      check("hold_no_ack_rd_pending", drain_ack_o, 0);
      set_r(1); tick();
      set_r(0); #1;
      check("hold_ack_not_yet", drain_ack_o, 0);
      tick();
      check("hold_ack", drain_ack_o, 1);
      drain_req_i = 0;
      tick();
      check("hold_release", drain_ack_o, 0);

      // Simultaneous AW/B, then B underflow sets sticky error
      s_aw_valid_i = 1; m_aw_ready_i = 1;
      tick();
      b_valid_i = 1; b_ready_i = 1;
      tick();
      s_aw_valid_i = 0; #1;
      check("aw_b_same_cycle", wr_cnt_o, 1);
      check("err_before_unf", err_o, 0);
      tick();
      check("wr_back_zero", wr_cnt_o, 0);
      check("err_still_clear", err_o, 0);
      tick();
      b_valid_i = 0; b_ready_i = 0; #1;
      check("err_set", err_o, 1);
      check("wr_unf_held_zero", wr_cnt_o, 0);
      tick(); tick();
      check("err_sticky", err_o, 1);

      // Asynchronous reset mid-drain
      s_aw_valid_i = 1; s_ar_valid_i = 1; m_ar_ready_i = 1;
      tick(); tick();
      s_aw_valid_i = 0; s_ar_valid_i = 0; drain_req_i = 1; #1;
      check("pre_rst_wr", wr_cnt_o, 2);
      check("pre_rst_rd", rd_cnt_o, 2);
      tick();
      check("pre_rst_drain_aw_closed", s_aw_ready_o, 0);
      #2 rst_i = 1'b1;
      #1;
      check("arst_wr", wr_cnt_o, 0);
      check("arst_rd", rd_cnt_o, 0);
      check("arst_err", err_o, 0);
      check("arst_ack", drain_ack_o, 0);
      check("arst_state_run", s_aw_ready_o, 1);
      drain_req_i = 0; m_aw_ready_i = 0; m_ar_ready_i = 0;
      tick();
      rst_i = 1'b0;
      tick();
      check("post_rst_ack", drain_ack_o, 0);
      check("post_rst_wr", wr_cnt_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
